rs544522_synd_lal8: RTL and testbench

RS544522_SYND_LAL8 -- requirements
Module: rs544522_synd_lal8

---
 rtl/rs544522_synd_lal8.sv | 170 +++++++++++++++++
 tb/tb_rs544522_synd_lal8.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs544522_synd_lal8.sv
// rs544522_synd_lal8 : RS(544,522) syndrome calculator over GF(2^10), 8 symbols per beat.
//
// Computes S_j = c(alpha^j), j = 0..R-1, with the codeword received highest degree first
// (codeword[N-1] in lane 0 of the first beat). Field polynomial x^10 + x^3 + 1.
//
// Optional feature macro: RS544_SYND_PROTOCHK_EN enables the frame-length check
// (proto_err_o); without it proto_err_o is tied low and no beat counter exists.
//
// Ports:
//   clk_i         clock, rising edge
//   rst_ni        asynchronous reset, active high
//   start_i       first beat of a codeword (qualified by valid_i)
//   valid_i       s_blk_i carries L symbols this cycle
//   last_i        final beat of a codeword (qualified by valid_i)
//   s_blk_i       L x W symbols, lane i at bits [i*W +: W], lane 0 = highest degree
//   synd_valid_o  one-cycle pulse, synd_o/zero_o updated
//   synd_o        R x W syndromes, S_j at bits [j*W +: W]
//   zero_o        all syndromes zero
//   busy_o        a frame is being accumulated
//   proto_err_o   frame-length violation (macro build only)
//
// state | meaning
// IDLE  | no frame open; only a valid start beat is accepted
// ACC   | frame open; valid beats fold into the accumulator

module rs544522_synd_lal8 #(
   parameter int W = 10,
   parameter int R = 22,
   parameter int L = 8,
   parameter int N = 544
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  logic             valid_i,
   input  logic             last_i,
   input  logic [L*W-1:0]   s_blk_i,
   output logic             synd_valid_o,
   output logic [R*W-1:0]   synd_o,
   output logic             zero_o,
   output logic             busy_o,
   output logic             proto_err_o
);

   localparam logic [W-1:0] POLY_LOW = W'(9);

   typedef enum logic {IDLE, ACC} state_t;

   function automatic logic [W-1:0] xtime(input logic [W-1:0] a);
      return {a[W-2:0], 1'b0} ^ (a[W-1] ? POLY_LOW : '0);
   endfunction

   function automatic logic [W-1:0] gf_mul(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W-1:0] p;
      p = '0;
      for (int k = W - 1; k >= 0; k--) begin
         p = xtime(p);
         if (b[k]) p = p ^ a;
      end
      return p;
   endfunction

   function automatic logic [W-1:0] alpha_pow(input int e);
      logic [W-1:0] p;
      p = W'(1);
      for (int k = 0; k < e; k++) p = xtime(p);
      return p;
   endfunction

   state_t                 state;
   logic [R-1:0][W-1:0]    acc;
   logic [R-1:0][W-1:0]    beat_sum;
   logic [R-1:0][W-1:0]    acc_next;

   // A partial final beat is not supported; N must be a whole number of beats.
   if ((N % L) != 0) begin : g_partial_beat_unsupported
   end

   for (genvar j = 0; j < R; j++) begin : g_synd
      localparam logic [W-1:0] C_ACC = alpha_pow(j * L);
      logic [L-1:0][W-1:0] terms;
      logic [W-1:0]        lane_sum;

      for (genvar i = 0; i < L; i++) begin : g_lane
         localparam logic [W-1:0] C_LANE = alpha_pow(j * (L - 1 - i));
         assign terms[i] = gf_mul(s_blk_i[i*W +: W], C_LANE);
      end

      always_comb begin
         lane_sum = '0;
         for (int i = 0; i < L; i++) lane_sum = lane_sum ^ terms[i];
      end

      assign beat_sum[j] = lane_sum;
      assign acc_next[j] = gf_mul(acc[j], C_ACC) ^ lane_sum;
   end

   assign busy_o = (state == ACC);

`ifdef RS544_SYND_PROTOCHK_EN
   localparam logic [6:0] BEATS = 7'(N / L);
   logic [6:0] cnt;
   logic [6:0] cnt_inc;

   assign cnt_inc = (cnt == 7'd127) ? cnt : cnt + 7'd1;
`else
   assign proto_err_o = 1'b0;
`endif

   always_ff @(posedge clk_i or posedge rst_ni) begin
      if (rst_ni) begin
         state        <= IDLE;
         acc          <= '0;
         synd_o       <= '0;
         zero_o       <= 1'b0;
         synd_valid_o <= 1'b0;
`ifdef RS544_SYND_PROTOCHK_EN
         cnt          <= '0;
         proto_err_o  <= 1'b0;
`endif
      end else begin
         synd_valid_o <= 1'b0;
`ifdef RS544_SYND_PROTOCHK_EN
         proto_err_o  <= 1'b0;
`endif
         if (valid_i) begin
            if (start_i) begin
               // A start always opens a fresh frame, discarding any open one.
               acc <= beat_sum;
`ifdef RS544_SYND_PROTOCHK_EN
               cnt <= 7'd1;
`endif
               if (last_i) begin
                  synd_o       <= beat_sum;
                  zero_o       <= (beat_sum == '0);
                  synd_valid_o <= 1'b1;
                  state        <= IDLE;
`ifdef RS544_SYND_PROTOCHK_EN
                  proto_err_o  <= (BEATS != 7'd1);
`endif
               end else begin
                  state <= ACC;
               end
            end else if (state == ACC) begin
               acc <= acc_next;
`ifdef RS544_SYND_PROTOCHK_EN
               cnt <= cnt_inc;
`endif
               if (last_i) begin
                  synd_o       <= acc_next;
                  zero_o       <= (acc_next == '0);
                  synd_valid_o <= 1'b1;
                  state        <= IDLE;
`ifdef RS544_SYND_PROTOCHK_EN
                  proto_err_o  <= (cnt_inc != BEATS);
`endif
               end
`ifdef RS544_SYND_PROTOCHK_EN
               else if (cnt == BEATS) begin
                  // One beat past a full codeword with no last: abandon the frame.
                  proto_err_o <= 1'b1;
                  state       <= IDLE;
               end
`endif
            end
         end
      end
   end

endmodule

// File: tb/tb_rs544522_synd_lal8.sv
module tb_rs544522_synd_lal8;

   localparam int W  = 10;
   localparam int R  = 22;
   localparam int L  = 8;
   localparam int N  = 544;
   localparam int NB = N / L;
`ifdef RS544_SYND_PROTOCHK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic             clk_i = 1'b0;
   logic             rst_ni = 1'b1;
   logic             start_i = 1'b0;
   logic             valid_i = 1'b0;
   logic             last_i = 1'b0;
   logic [L*W-1:0]   s_blk_i = '0;
   logic             synd_valid_o;
   logic [R*W-1:0]   synd_o;
   logic             zero_o;
   logic             busy_o;
   logic             proto_err_o;

   rs544522_synd_lal8 #(.W(W), .R(R), .L(L), .N(N)) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .start_i      (start_i),
      .valid_i      (valid_i),
      .last_i       (last_i),
      .s_blk_i      (s_blk_i),
      .synd_valid_o (synd_valid_o),
      .synd_o       (synd_o),
      .zero_o       (zero_o),
      .busy_o       (busy_o),
      .proto_err_o  (proto_err_o)
   );

   always #5 clk_i = ~clk_i;

   int unsigned cyc = 0;
   always @(posedge clk_i) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_err = 0;

   // GF(2^10) log/antilog tables and the code generator polynomial
   int exp_t [0:1022];
   int log_t [0:1023];
   int gen   [0:22];
   logic [9:0] cw [0:N-1];

   typedef struct {
      logic [R*W-1:0] synd;
      logic           zero;
      logic           sv;
      logic           pe;
      int unsigned    cyc;
   } exp_s;
   exp_s sb[$];

   // reference frame: the symbols of the currently open frame in arrival order
   logic [9:0] fq[$];
   bit         active = 1'b0;
   int         fcnt = 0;

   function automatic int gmul(input int a, input int b);
      if (a == 0 || b == 0) return 0;
      return exp_t[(log_t[a] + log_t[b]) % 1023];
   endfunction

   function automatic logic [R*W-1:0] eval_synd();
      logic [R*W-1:0] res;
      int n, s, sym;
      res = '0;
      n = fq.size();
      for (int j = 0; j < R; j++) begin
         s = 0;
         for (int p = 0; p < n; p++) begin
            sym = int'(fq[p]);
            if (sym != 0) s = s ^ exp_t[(log_t[sym] + j * (n - 1 - p)) % 1023];
         end
         res[j*W +: W] = 10'(s);
      end
      return res;
   endfunction

   task automatic check(input string name, input logic [R*W-1:0] act, input logic [R*W-1:0] want);
      n_cmp++;
      if (act !== want) begin
         n_err++;
         $display("FAIL %s: got %h want %h", name, act, want);
      end
   endtask

   task automatic build_tables();
      int x;
      x = 1;
      for (int e = 0; e < 1023; e++) begin
         exp_t[e] = x;
         log_t[x] = e;
         x = x << 1;
         if ((x & 32'h400) != 0) x = x ^ 32'h409;
      end
      for (int k = 0; k <= 22; k++) gen[k] = 0;
      gen[0] = 1;
      for (int j = 0; j < R; j++) begin
         for (int k = j + 1; k >= 1; k--) gen[k] = gen[k-1] ^ gmul(gen[k], exp_t[j]);
         gen[0] = gmul(gen[0], exp_t[j]);
      end
   endtask

   // systematic encoder: random message in cw[543:22], parity = remainder mod gen
   task automatic encode();
      int rem [0:21];
      int fb;
      for (int k = 0; k < R; k++) rem[k] = 0;
      for (int k = R; k < N; k++) cw[k] = 10'($urandom_range(0, 1023));
      for (int k = N - 1; k >= R; k--) begin
         fb = int'(cw[k]) ^ rem[R-1];
         for (int t = R - 1; t >= 1; t--) rem[t] = rem[t-1] ^ gmul(fb, gen[t]);
         rem[0] = gmul(fb, gen[0]);
      end
      for (int k = 0; k < R; k++) cw[k] = 10'(rem[k]);
   endtask

   function automatic logic [L*W-1:0] rand_blk();
      logic [95:0] r;
      r = {$urandom(), $urandom(), $urandom()};
      return r[L*W-1:0];
   endfunction

   task automatic drive_beat(input bit st, input bit ls, input logic [L*W-1:0] blk);
      exp_s e;
      @(negedge clk_i);
      start_i = st;
      last_i  = ls;
      s_blk_i = blk;
      valid_i = 1'b1;
      if (st) begin
         fq.delete();
         active = 1'b1;
         fcnt = 0;
      end
      if (active) begin
         for (int i = 0; i < L; i++) fq.push_back(blk[i*W +: W]);
         fcnt++;
         if (ls) begin
            e.synd = eval_synd();
            e.zero = (e.synd == '0);
            e.sv   = 1'b1;
            e.pe   = CHK && (fcnt != NB);
            e.cyc  = cyc + 1;
            sb.push_back(e);
            active = 1'b0;
         end else if (CHK && fcnt == NB + 1) begin
            e.synd = '0;
            e.zero = 1'b0;
            e.sv   = 1'b0;
            e.pe   = 1'b1;
            e.cyc  = cyc + 1;
            sb.push_back(e);
            active = 1'b0;
         end
      end
   endtask

   task automatic bubble(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk_i);
         valid_i = 1'b0;
         start_i = 1'($urandom_range(0, 1));
         last_i  = 1'($urandom_range(0, 1));
         s_blk_i = rand_blk();
      end
   endtask

   task automatic send_cw(input int nbeats, input bit bub);
      logic [L*W-1:0] blk;
      for (int b = 0; b < nbeats; b++) begin
         for (int i = 0; i < L; i++) blk[i*W +: W] = cw[N - 1 - (b * L + i)];
         drive_beat(b == 0, b == NB - 1, blk);
         if (bub && (b == 0 || b == 33 || b == 66)) bubble(2);
      end
   endtask

   task automatic do_reset();
      @(negedge clk_i);
      rst_ni  = 1'b1;
      valid_i = 1'b0;
      fq.delete();
      active = 1'b0;
      fcnt = 0;
      @(negedge clk_i);
      check("rst_busy", busy_o, 1'b0);
      check("rst_valid", synd_valid_o, 1'b0);
      rst_ni = 1'b0;
   endtask

   // scoreboard monitor
   always @(negedge clk_i) begin
      exp_s e;
      if (!rst_ni && (synd_valid_o || proto_err_o)) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_output: got synd_valid=%b proto_err=%b at cycle %0d, want no output",
                     synd_valid_o, proto_err_o, cyc);
         end else begin
            e = sb.pop_front();
            check("latency_cycle", R*W'(cyc), R*W'(e.cyc));
            check("synd_valid", synd_valid_o, e.sv);
            check("proto_err", proto_err_o, e.pe);
            if (e.sv) begin
               check("synd", synd_o, e.synd);
               check("zero", zero_o, e.zero);
            end
         end
      end
   end

   initial begin
      logic [R*W-1:0] ones;
      build_tables();
      void'($urandom(32'h0544_0522));

      // reset state
      repeat (3) @(negedge clk_i);
      check("reset_synd", synd_o, '0);
      check("reset_zero", zero_o, 1'b0);
      check("reset_busy", busy_o, 1'b0);
      check("reset_valid", synd_valid_o, 1'b0);
      check("reset_proto", proto_err_o, 1'b0);
      rst_ni = 1'b0;
      @(negedge clk_i);

      // beats without a start while idle are ignored
      for (int k = 0; k < 3; k++) drive_beat(1'b0, 1'($urandom_range(0, 1)), rand_blk());
      bubble(2);
      check("ignored_busy", busy_o, 1'b0);

      // all-zero codeword
      for (int k = 0; k < N; k++) cw[k] = '0;
      send_cw(NB, 1'b0);
      bubble(3);
      check("idle_after_frame", busy_o, 1'b0);

      // three valid random codewords
      for (int t = 0; t < 3; t++) begin
         encode();
         send_cw(NB, 1'b0);
         bubble(2);
      end

      // single-symbol error patterns: S_j = 1, then S_j = alpha^j
      for (int k = 0; k < N; k++) cw[k] = '0;
      cw[0] = 10'h001;
      send_cw(NB, 1'b0);
      bubble(3);
      ones = '0;
      for (int j = 0; j < R; j++) ones[j*W] = 1'b1;
      check("cw0_synd_all_one", synd_o, ones);
      cw[0] = '0;
      cw[1] = 10'h001;
      send_cw(NB, 1'b0);
      bubble(3);
      check("cw1_s1", R*W'(synd_o[1*W +: W]), R*W'(10'h002));
      check("cw1_s10", R*W'(synd_o[10*W +: W]), R*W'(10'h009));

      // valid codeword with bubbles
      encode();
      send_cw(NB, 1'b1);
      bubble(2);

      // restart after 20 beats
      drive_beat(1'b1, 1'b0, rand_blk());
      for (int k = 1; k < 20; k++) drive_beat(1'b0, 1'b0, rand_blk());
      bubble(1);
      check("busy_mid_frame", busy_o, 1'b1);
      encode();
      send_cw(NB, 1'b0);
      bubble(2);

      // reset at beat 30 discards the frame
      encode();
      send_cw(30, 1'b0);
      do_reset();
      bubble(4);
      check("busy_after_reset", busy_o, 1'b0);

      // one-beat frame
      drive_beat(1'b1, 1'b1, rand_blk());
      bubble(2);

      // back-to-back frames: valid, random garbage, valid
      encode();
      send_cw(NB, 1'b0);
      for (int k = 0; k < N; k++) cw[k] = 10'($urandom_range(0, 1023));
      send_cw(NB, 1'b0);
      encode();
      send_cw(NB, 1'b0);
      bubble(2);

      // short frame, last at beat 10
      for (int b = 0; b < 10; b++) drive_beat(b == 0, b == 9, rand_blk());
      bubble(2);

      // random-length frames with random bubbles
      for (int f = 0; f < 6; f++) begin
         int len;
         len = $urandom_range(1, 75);
         for (int b = 0; b < len; b++) begin
            drive_beat(b == 0, b == len - 1, rand_blk());
            if ($urandom_range(0, 3) == 0) bubble($urandom_range(1, 3));
         end
         bubble(1);
      end

`ifdef RS544_SYND_PROTOCHK_EN
      // 69 beats without last: error pulse, no syndrome, frame aborted
      for (int b = 0; b < NB + 1; b++) drive_beat(b == 0, 1'b0, rand_blk());
      bubble(2);
      check("abort_busy", busy_o, 1'b0);
      drive_beat(1'b0, 1'b1, rand_blk());
      bubble(2);
`endif

      bubble(5);
      check("scoreboard_drained", R*W'(sb.size()), '0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
